puzzle_move_unit: RTL and testbench

Move-execution stage for the 8-puzzle datapath, sitting directly on the ports of the puzzle register file. On a start pulse it reads the nine board tiles from the register file, locates the blank tile, checks the requested move for legality, writes the two swapped tiles back, and reports whether the resulting board matches the goal board. It is the only writer of board state during a move; the search controller upstream issues moves and consumes `done`, `illegal`, `solved` and `move_count`.

---
 rtl/puzzle_move_unit.sv | 171 +++++++++++++++++
 tb/tb_puzzle_move_unit.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/puzzle_move_unit.sv
// Move-execution stage for the 8-puzzle: scans the board from the register file,
// validates the blank's move, writes the swapped tiles back and flags a solved board.
module puzzle_move_unit #(
  parameter logic [4:0]  BOARD_BASE = 5'd0,
  parameter logic [35:0] IDEAL      = 36'h1234_5678_0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] dir,
  output logic       busy,
  output logic       done,
  output logic       illegal,
  output logic       solved,
  output logic [3:0] blank_pos,
  output logic [7:0] move_count,
  output logic [4:0] rf_src0,
  output logic [4:0] rf_src1,
  input  logic [7:0] rf_data0,
  input  logic [7:0] rf_data1,
  output logic [4:0] rf_dst,
  output logic       rf_we,
  output logic [7:0] rf_wdata
);

  localparam int unsigned NT = 9;
  localparam int unsigned TW = 4;
  localparam int unsigned AW = 5;
  localparam int unsigned BW = NT * TW;

  typedef enum logic [2:0] {IDLE, SCAN, CHECK, WR0, WR1, DONE} state_t;

  state_t        state, state_n;
  logic [2:0]    idx, idx_n;
  logic [1:0]    dir_q;
  logic [TW-1:0] tile [NT];
  logic [TW-1:0] n_q;
  logic          we_q;

  logic [AW-1:0] src0_n, src1_n, dst_n;
  logic [7:0]    wdata_n;
  logic          we_n;

  logic [3:0]    nz_c, b_c, n_c;
  logic [1:0]    col_c;
  logic          malformed_c, legal_c, solved_c;
  logic [TW-1:0] tile_n_c;
  logic [BW-1:0] cur_c, post_c;

  logic unused_hi;
  assign unused_hi = ^{rf_data0[7:4], rf_data1[7:4]};

  // A reset cycle cancels any write in flight, so a reset during WR1 leaves only the WR0 write.
  assign rf_we = we_q & ~rst;

  // Blank search, move legality and goal comparison on the scanned board.
  always_comb begin
    nz_c     = '0;
    b_c      = '0;
    n_c      = '0;
    legal_c  = 1'b0;
    tile_n_c = '0;
    cur_c    = '0;
    post_c   = '0;
    for (int i = 0; i < NT; i++) begin
      if (tile[i] == 4'd0) begin
        nz_c = nz_c + 4'd1;
        b_c  = 4'(i);
      end
    end
    malformed_c = (nz_c != 4'd1);
    col_c = 2'(b_c % 4'd3);
    case (dir_q)
      2'b00: begin legal_c = (b_c >= 4'd3); n_c = b_c - 4'd3; end
      2'b01: begin legal_c = (b_c <= 4'd5); n_c = b_c + 4'd3; end
      2'b10: begin legal_c = (col_c != 2'd0); n_c = b_c - 4'd1; end
      default: begin legal_c = (col_c != 2'd2); n_c = b_c + 4'd1; end
    endcase
    legal_c = legal_c & ~malformed_c;
    for (int i = 0; i < NT; i++) begin
      if (4'(i) == n_c) tile_n_c = tile[i];
    end
    for (int i = 0; i < NT; i++) begin
      cur_c[BW-1-TW*i -: TW] = tile[i];
      if (4'(i) == b_c)      post_c[BW-1-TW*i -: TW] = tile_n_c;
      else if (4'(i) == n_c) post_c[BW-1-TW*i -: TW] = 4'd0;
      else                   post_c[BW-1-TW*i -: TW] = tile[i];
    end
    solved_c = legal_c ? (post_c == IDEAL) : (cur_c == IDEAL);
  end

  // Next state plus the register-file drive for the following cycle.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    src0_n  = BOARD_BASE;
    src1_n  = BOARD_BASE;
    dst_n   = BOARD_BASE;
    wdata_n = '0;
    we_n    = 1'b0;
    case (state)
      IDLE:    if (start) begin state_n = SCAN; idx_n = '0; end
      SCAN:    if (idx == 3'd4) state_n = CHECK; else idx_n = idx + 3'd1;
      CHECK:   state_n = legal_c ? WR0 : DONE;
      WR0:     state_n = WR1;
      WR1:     state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (state_n == SCAN) begin
      src0_n = BOARD_BASE + AW'({idx_n, 1'b0});
      src1_n = (idx_n == 3'd4) ? src0_n : src0_n + 5'd1;
    end
    if (state_n == WR0) begin
      dst_n   = BOARD_BASE + AW'(b_c);
      wdata_n = 8'(tile_n_c);
      we_n    = 1'b1;
    end
    if (state_n == WR1) begin
      dst_n = BOARD_BASE + AW'(n_q);
      we_n  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      dir_q      <= '0;
      n_q        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      illegal    <= 1'b0;
      solved     <= 1'b0;
      blank_pos  <= '0;
      move_count <= '0;
      rf_src0    <= BOARD_BASE;
      rf_src1    <= BOARD_BASE;
      rf_dst     <= BOARD_BASE;
      rf_wdata   <= '0;
      we_q       <= 1'b0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      busy     <= (state_n != IDLE);
      done     <= (state_n == DONE);
      rf_src0  <= src0_n;
      rf_src1  <= src1_n;
      rf_dst   <= dst_n;
      rf_wdata <= wdata_n;
      we_q     <= we_n;
      if (state == IDLE && start) dir_q <= dir;
      if (state == CHECK) begin
        illegal   <= ~legal_c;
        solved    <= solved_c;
        blank_pos <= malformed_c ? 4'hF : b_c;
        n_q       <= n_c;
      end
      if (state == WR1 && move_count != 8'hFF) move_count <= move_count + 8'd1;
    end
  end

  // Tile capture: scan step k holds positions 2k and 2k+1 on the two read ports.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NT; i++) begin
      if (state == SCAN && 3'(i / 2) == idx)
        tile[i] <= (i % 2 == 0) ? rf_data0[3:0] : rf_data1[3:0];
    end
  end

endmodule

// File: tb/tb_puzzle_move_unit.sv
// Directed bench for puzzle_move_unit with a behavioural register file.
module tb_puzzle_move_unit;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [1:0] dir;
  logic       busy, done, illegal, solved, rf_we;
  logic [3:0] blank_pos;
  logic [7:0] move_count, rf_data0, rf_data1, rf_wdata;
  logic [4:0] rf_src0, rf_src1, rf_dst;

  logic [7:0] rf [32];
  int errors = 0;
  int checks = 0;
  int wr_addr [2];
  int wr_data [2];
  int wr_cyc  [2];
  int done_at, nwr, busy_cyc, bad;

  localparam logic [35:0] B_DOWN5 = 36'h1234_5078_6;
  localparam logic [35:0] B_NOZ   = 36'h1234_5678_1;
  localparam logic [35:0] B_LEFT3 = 36'h1230_4567_8;
  localparam logic [35:0] B_IDEAL = 36'h1234_5678_0;

  always #5 clk = ~clk;

  puzzle_move_unit dut (
    .clk(clk), .rst(rst), .start(start), .dir(dir),
    .busy(busy), .done(done), .illegal(illegal), .solved(solved),
    .blank_pos(blank_pos), .move_count(move_count),
    .rf_src0(rf_src0), .rf_src1(rf_src1),
    .rf_data0(rf_data0), .rf_data1(rf_data1),
    .rf_dst(rf_dst), .rf_we(rf_we), .rf_wdata(rf_wdata)
  );

  assign rf_data0 = rf[rf_src0];
  assign rf_data1 = rf[rf_src1];

  always @(posedge clk) if (rf_we) rf[rf_dst] <= rf_wdata;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Upper nibbles are filled with A so ignored read bits are exercised.
  task automatic load_board(input logic [35:0] b);
    @(negedge clk);
    for (int i = 0; i < 9; i++) rf[5'(i)] <= {4'hA, b[35-4*i -: 4]};
  endtask

  task automatic run_move(input logic [1:0] d, input bit glitch, input int rst_at,
                          output int d_at, output int n_wr, output int n_busy);
    d_at = -1; n_wr = 0; n_busy = 0;
    @(negedge clk);
    start = 1'b1;
    dir   = d;
    for (int k = 1; k <= 12 && d_at < 0; k++) begin
      @(negedge clk);
      start = glitch && (k == 3 || k == 8);
      dir   = ~d;
      rst   = (k == rst_at);
      #1;
      if (busy) n_busy++;
      if (rf_we) begin
        if (n_wr < 2) begin
          wr_addr[n_wr] = 32'(rf_dst);
          wr_data[n_wr] = 32'(rf_wdata);
          wr_cyc[n_wr]  = k;
        end
        n_wr++;
      end
      if (done) d_at = k;
    end
    start = 1'b0;
    rst   = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; dir = 2'b00;
    for (int i = 0; i < 32; i++) rf[i] = 8'h5A;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("rst_we", 32'(rf_we), 0);
    end
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_illegal", 32'(illegal), 0);
    check("rst_solved", 32'(solved), 0);
    check("rst_blank", 32'(blank_pos), 0);
    check("rst_count", 32'(move_count), 0);
    check("rst_wdata", 32'(rf_wdata), 0);
    rst = 1'b0;

    // Legal move down from position 5 reaches the goal
    load_board(B_DOWN5);
    run_move(2'b01, 1'b0, 0, done_at, nwr, busy_cyc);
    check("t1_done_at", done_at, 9);
    check("t1_busy_cyc", busy_cyc, 9);
    check("t1_nwr", nwr, 2);
    check("t1_wa0", wr_addr[0], 5);
    check("t1_wd0", wr_data[0], 6);
    check("t1_wc0", wr_cyc[0], 7);
    check("t1_wa1", wr_addr[1], 8);
    check("t1_wd1", wr_data[1], 0);
    check("t1_wc1", wr_cyc[1], 8);
    check("t1_blank", 32'(blank_pos), 5);
    check("t1_illegal", 32'(illegal), 0);
    check("t1_solved", 32'(solved), 1);
    check("t1_count", 32'(move_count), 1);
    check("t1_rf5", 32'(rf[5]), 8'h06);
    check("t1_rf8", 32'(rf[8]), 8'h00);
    @(negedge clk);
    check("t1_busy_after", 32'(busy), 0);
    check("t1_done_after", 32'(done), 0);

    // Right from the right column is rejected
    load_board(B_DOWN5);
    run_move(2'b11, 1'b0, 0, done_at, nwr, busy_cyc);
    check("t2_done_at", done_at, 7);
    check("t2_busy_cyc", busy_cyc, 7);
    check("t2_nwr", nwr, 0);
    check("t2_illegal", 32'(illegal), 1);
    check("t2_blank", 32'(blank_pos), 5);
    check("t2_solved", 32'(solved), 0);
    check("t2_count", 32'(move_count), 1);

    // Board without a blank is malformed
    load_board(B_NOZ);
    run_move(2'b00, 1'b0, 0, done_at, nwr, busy_cyc);
    check("t3_done_at", done_at, 7);
    check("t3_nwr", nwr, 0);
    check("t3_blank", 32'(blank_pos), 15);
    check("t3_illegal", 32'(illegal), 1);
    check("t3_solved", 32'(solved), 0);
    check("t3_rf8", 32'(rf[8]), 8'hA1);
    check("t3_rf0", 32'(rf[0]), 8'hA1);

    // Left from the left column is rejected
    load_board(B_LEFT3);
    run_move(2'b10, 1'b0, 0, done_at, nwr, busy_cyc);
    check("t4_done_at", done_at, 7);
    check("t4_blank", 32'(blank_pos), 3);
    check("t4_illegal", 32'(illegal), 1);
    check("t4_count", 32'(move_count), 1);

    // Starts while busy are dropped; a start right after DONE runs
    load_board(B_IDEAL);
    run_move(2'b00, 1'b1, 0, done_at, nwr, busy_cyc);
    check("t5_done_at", done_at, 9);
    check("t5_nwr", nwr, 2);
    check("t5_wa0", wr_addr[0], 8);
    check("t5_wd0", wr_data[0], 6);
    check("t5_wa1", wr_addr[1], 5);
    check("t5_blank", 32'(blank_pos), 8);
    check("t5_solved", 32'(solved), 0);
    check("t5_count", 32'(move_count), 2);
    run_move(2'b01, 1'b0, 0, done_at, nwr, busy_cyc);
    check("t5b_done_at", done_at, 9);
    check("t5b_blank", 32'(blank_pos), 5);
    check("t5b_wa0", wr_addr[0], 5);
    check("t5b_solved", 32'(solved), 1);
    check("t5b_count", 32'(move_count), 3);

    // Reset during WR1: only the first write lands, no done
    load_board(B_DOWN5);
    run_move(2'b01, 1'b0, 8, done_at, nwr, busy_cyc);
    check("t6_done_at", done_at, -1);
    check("t6_nwr", nwr, 1);
    check("t6_wa0", wr_addr[0], 5);
    check("t6_wd0", wr_data[0], 6);
    check("t6_count", 32'(move_count), 0);
    check("t6_busy", 32'(busy), 0);
    check("t6_rf5", 32'(rf[5]), 8'h06);
    check("t6_rf8", 32'(rf[8]), 8'hA6);

    // Move counter saturates at 255
    load_board(B_DOWN5);
    bad = 0;
    for (int m = 0; m < 256; m++) begin
      run_move((m % 2 == 0) ? 2'b01 : 2'b00, 1'b0, 0, done_at, nwr, busy_cyc);
      if (done_at != 9 || nwr != 2) bad++;
      if (m == 254) check("t7_count255", 32'(move_count), 255);
    end
    check("t7_bad_moves", bad, 0);
    check("t7_count_sat", 32'(move_count), 255);
    check("t7_solved", 32'(solved), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
